// File: rtl/fft_cp_framer_pkg.sv
// Shared types and helpers for the cyclic-prefix framer.
package fft_cp_framer_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int MAX_LEN_LOG2_DEF = 11;
    localparam int MIN_LEN_LOG2     = 3;

    // Out-of-range sizes are clamped rather than rejected.
    function automatic int unsigned len_from_log2(input logic [3:0] lg, input int unsigned max_lg);
        int unsigned l;
        l = int'(lg);
        if (l < MIN_LEN_LOG2) l = MIN_LEN_LOG2;
        if (l > max_lg) l = max_lg;
        return 32'd1 << l;
    endfunction

endpackage

// File: rtl/fft_cp_framer_skid.sv
// Two-entry register slice: ready towards upstream depends only on fill level.
module axis_skid_buf #(
    parameter int W = 33
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    input  logic         dn_ready
);
    logic [1:0]   cnt;
    logic [W-1:0] head, tail;
    logic         push, pop;

    assign push     = up_valid && up_ready;
    assign pop      = dn_valid && dn_ready;
    assign up_ready = (cnt != 2'd2);
    assign dn_valid = (cnt != 2'd0);
    assign dn_data  = head;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= up_data;
                    else             tail <= up_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= up_data;
                    end else begin
                        head <= up_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fft_cp_framer.sv
// Strips the cyclic prefix of each OFDM symbol and frames N samples with TLAST.
// Optional statistics counters: define FFT_CP_FRAMER_STATS_EN.
module fft_cp_framer
    import fft_cp_framer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MAX_LEN_LOG2 = MAX_LEN_LOG2_DEF,
    parameter int CP_W         = 12
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_enable,
    input  logic [3:0]        cfg_fft_len_log2,
    input  logic [CP_W-1:0]   cfg_cp_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              sync_err,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       err_cnt
);
    localparam int IDX_W = CP_W + 1;
    localparam int NW    = MAX_LEN_LOG2 + 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, last_idx;
    logic [CP_W-1:0]   cp_q, cp_d;
    logic [NW-1:0]     n_q, n_d, n_cfg;
    logic              alive, fwd, at_last, acc, push, err, skid_rdy, last_in;
    logic [DATA_W:0]   dn_data;

    assign n_cfg    = NW'(len_from_log2(cfg_fft_len_log2, MAX_LEN_LOG2));
    assign last_idx = IDX_W'(cp_q) + IDX_W'(n_q) - IDX_W'(1);
    assign fwd      = (idx_q >= IDX_W'(cp_q));
    assign at_last  = (idx_q == last_idx);
    assign last_in  = (state_q == RUN) && at_last;

    // Prefix beats never need buffer space, so they are accepted even when the slice is full.
    assign s_axis_tready = alive && ((state_q == IDLE) ? (skid_rdy || (cfg_cp_len != '0))
                                                       : (!fwd || skid_rdy));
    assign acc = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cp_d    = cp_q;
        n_d     = n_q;
        push    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && s_axis_tuser && cfg_enable) begin
                    cp_d    = cfg_cp_len;
                    n_d     = n_cfg;
                    idx_d   = IDX_W'(1);
                    push    = (cfg_cp_len == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    if (idx_q == '0 && !s_axis_tuser) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // A stray start marker is reported but the beat keeps its slot.
                        err  = (idx_q != '0) && s_axis_tuser;
                        push = fwd;
                        if (at_last) begin
                            if (err || !cfg_enable) begin
                                state_d = IDLE;
                            end else begin
                                idx_d = '0;
                                cp_d  = cfg_cp_len;
                                n_d   = n_cfg;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cp_q     <= '0;
            n_q      <= '0;
            alive    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cp_q     <= cp_d;
            n_q      <= n_d;
            alive    <= 1'b1;
            sync_err <= err;
        end
    end

    axis_skid_buf #(.W(DATA_W + 1)) u_skid (
        .gclk     (ACLK),
        .grst_n   (ARESETN),
        .up_valid (push),
        .up_data  ({last_in, s_axis_tdata}),
        .up_ready (skid_rdy),
        .dn_valid (m_axis_tvalid),
        .dn_data  (dn_data),
        .dn_ready (m_axis_tready)
    );

    assign m_axis_tlast = dn_data[DATA_W];
    assign m_axis_tdata = dn_data[DATA_W-1:0];

`ifdef FFT_CP_FRAMER_STATS_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
            if (sync_err && err_cnt != 16'hFFFF)                err_cnt   <= err_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif
endmodule

// File: tb/tb_fft_cp_framer.sv
// Self-checking bench for fft_cp_framer against a symbol-level reference model.
module tb_fft_cp_framer;
    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [3:0]  cfg_fft_len_log2 = 4'd4;
    logic [11:0] cfg_cp_len = 12'd0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        sync_err;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;

    fft_cp_framer dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
        .cfg_fft_len_log2(cfg_fft_len_log2), .cfg_cp_len(cfg_cp_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .sync_err(sync_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic        tuser;
        logic        en;
        logic [3:0]  lg;
        logic [11:0] cp;
    } beat_t;

    beat_t       bl[$];
    logic [32:0] exp_q[$], got_q[$];
    int          got_cyc[$];
    int          checks = 0, errors = 0;
    int          exp_err = 0, err_seen = 0, hold_bad = 0, cyc = 0;
    int          gbase = 0, ebase = 0, hbase = 0;
    int          rdy_mode = 0, data_ctr = 0;
    bit          gap_en = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sole writer of the capture queue and event counters.
    initial begin
        logic        stall_prev;
        logic [32:0] prev_beat;
        stall_prev = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESETN) begin
                if (stall_prev && m_axis_tvalid && {m_axis_tlast, m_axis_tdata} !== prev_beat)
                    hold_bad++;
                if (m_axis_tvalid && m_axis_tready) begin
                    got_q.push_back({m_axis_tlast, m_axis_tdata});
                    got_cyc.push_back(cyc);
                end
                if (sync_err) err_seen++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = !m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic int frame_len(input int lg);
        int l;
        l = (lg < 3) ? 3 : (lg > 11) ? 11 : lg;
        return 1 << l;
    endfunction

    // Reference: walk the accepted beat stream symbol by symbol.
    task automatic run_model();
        bit in_sym;
        bit bad;
        int k, cp, n;
        in_sym = 0; k = 0; cp = 0; n = 0;
        foreach (bl[i]) begin
            bad = 0;
            if (!in_sym) begin
                if (!(bl[i].tuser && bl[i].en)) continue;
                in_sym = 1; k = 0; cp = int'(bl[i].cp); n = frame_len(int'(bl[i].lg));
            end else if (k == 0 && !bl[i].tuser) begin
                exp_err++;
                in_sym = 0;
                continue;
            end else if (k != 0 && bl[i].tuser) begin
                exp_err++;
                bad = 1;
            end
            if (k >= cp) exp_q.push_back({(k == cp + n - 1), bl[i].data});
            if (k == cp + n - 1) begin
                if (bad || !bl[i].en) in_sym = 0;
                else begin
                    k = 0; cp = int'(bl[i].cp); n = frame_len(int'(bl[i].lg));
                end
            end else k++;
        end
    endtask

    // One symbol of cp+N beats; the closing beat carries the next symbol's config.
    task automatic add_sym(input int cp, input int lg, input int ncp, input int nlg,
                           input bit tu, input bit en_last, input bit rnd);
        beat_t b;
        int    tot;
        tot = cp + frame_len(lg);
        for (int k = 0; k < tot; k++) begin
            b.data  = rnd ? $urandom : 32'(data_ctr);
            data_ctr++;
            b.tuser = (k == 0) ? tu : 1'b0;
            b.en    = (k == tot - 1) ? en_last : 1'b1;
            b.cp    = 12'((k == tot - 1) ? ncp : cp);
            b.lg    = 4'((k == tot - 1) ? nlg : lg);
            bl.push_back(b);
        end
    endtask

    task automatic add_junk(input int cnt);
        beat_t b;
        for (int k = 0; k < cnt; k++) begin
            b = '{data: $urandom, tuser: 1'b0, en: 1'b1, lg: 4'd4, cp: 12'd4};
            bl.push_back(b);
        end
    endtask

    task automatic send_all();
        bit ok;
        int t;
        foreach (bl[i]) begin
            if (gap_en) repeat ($urandom_range(0, 2)) begin
                s_axis_tvalid = 1'b0;
                @(posedge ACLK); #1;
            end
            s_axis_tvalid    = 1'b1;
            s_axis_tdata     = bl[i].data;
            s_axis_tuser     = bl[i].tuser;
            cfg_enable       = bl[i].en;
            cfg_cp_len       = bl[i].cp;
            cfg_fft_len_log2 = bl[i].lg;
            t = 0;
            do begin
                @(negedge ACLK);
                ok = s_axis_tready;
                @(posedge ACLK); #1;
                t++;
            end while (!ok && t < 1000);
            if (!ok) chk("accept_timeout", 1, 0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic begin_test(input int mode, input bit gaps);
        rdy_mode = mode;
        gap_en   = gaps;
        do_reset();
        bl.delete();
        exp_q.delete();
        exp_err = 0;
        gbase = got_q.size();
        ebase = err_seen;
        hbase = hold_bad;
    endtask

    task automatic check_run(input string nm);
        int t, frames;
        t = 0; frames = 0;
        while (got_q.size() - gbase < exp_q.size() && t < 3000) begin
            @(posedge ACLK); #1; t++;
        end
        repeat (4) @(posedge ACLK);
        #1;
        chk({nm, "_count"}, 64'(got_q.size() - gbase), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++)
            chk({nm, "_beat"}, 64'(got_q[gbase + i]), 64'(exp_q[i]));
        chk({nm, "_sync_err"}, 64'(err_seen - ebase), 64'(exp_err));
        chk({nm, "_hold"}, 64'(hold_bad - hbase), 64'd0);
        foreach (exp_q[i]) frames += int'(exp_q[i][32]);
`ifdef FFT_CP_FRAMER_STATS_EN
        chk({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(frames));
        chk({nm, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
`else
        chk({nm, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        chk({nm, "_err_cnt"}, 64'(err_cnt), 64'd0);
`endif
    endtask

    initial begin
        int c, l, nc, nl, sz;
        c = 0; l = 0;

        // Reset values
        #12;
        chk("rst_s_tready", 64'(s_axis_tready), 0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 0);
        chk("rst_m_tdata", 64'(m_axis_tdata), 0);
        chk("rst_sync_err", 64'(sync_err), 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0);
        chk("rst_err_cnt", 64'(err_cnt), 0);

        // Two symbols N=16 cp=4, data 0..39
        begin_test(0, 0);
        data_ctr = 0;
        add_sym(4, 4, 4, 4, 1, 1, 0);
        add_sym(4, 4, 4, 4, 1, 0, 0);
        run_model(); send_all(); check_run("basic");

        // Same stimulus under a toggling sink
        begin_test(1, 0);
        data_ctr = 0;
        add_sym(4, 4, 4, 4, 1, 1, 0);
        add_sym(4, 4, 4, 4, 1, 0, 0);
        run_model(); send_all(); check_run("stall");

        // Missing start marker on second symbol
        begin_test(0, 0);
        add_sym(4, 4, 4, 4, 1, 1, 1);
        add_junk(10);
        add_sym(4, 4, 4, 4, 1, 0, 1);
        run_model(); send_all(); check_run("nostart");

        // cp=0, N=8, back-to-back frames
        begin_test(0, 0);
        add_sym(0, 3, 0, 3, 1, 1, 1);
        add_sym(0, 3, 0, 3, 1, 1, 1);
        add_sym(0, 3, 0, 3, 1, 0, 1);
        run_model(); send_all(); check_run("cp0");
        sz = got_q.size();
        if (sz - gbase == 24)
            chk("cp0_gapless", 64'(got_cyc[sz - 1] - got_cyc[gbase]), 64'd23);
        else
            chk("cp0_gapless_n", 64'(sz - gbase), 64'd24);

        // Reset after output 7 of 16
        begin_test(0, 0);
        for (int k = 0; k < 12; k++)
            bl.push_back('{data: $urandom, tuser: (k == 0), en: 1'b1, lg: 4'd4, cp: 12'd4});
        run_model(); send_all();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk("midrst_m_tvalid", 64'(m_axis_tvalid), 0);
        chk("midrst_s_tready", 64'(s_axis_tready), 0);
        chk("midrst_count", 64'(got_q.size() - gbase), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++)
            chk("midrst_beat", 64'(got_q[gbase + i]), 64'(exp_q[i]));
        @(posedge ACLK); #1 ARESETN = 1'b1;
        bl.delete(); exp_q.delete(); exp_err = 0;
        gbase = got_q.size(); ebase = err_seen; hbase = hold_bad;
        add_junk(5);
        add_sym(4, 4, 4, 4, 1, 0, 1);
        run_model(); send_all(); check_run("postrst");

        // Size change in the middle of a symbol takes effect on the next one
        begin_test(0, 0);
        add_sym(4, 4, 4, 5, 1, 1, 1);
        for (int i = 10; i < 19; i++) bl[i].lg = 4'd5;
        add_sym(4, 5, 4, 5, 1, 0, 1);
        run_model(); send_all(); check_run("lenchg");
        chk("lenchg_frames", 64'(exp_q.size()), 64'd48);

        // Randomized symbols: random cp/size (some illegal), gaps, random sink, injected faults
        begin_test(2, 1);
        c = $urandom_range(0, 6); l = $urandom_range(1, 4);
        for (int s = 0; s < 6; s++) begin
            nc = $urandom_range(0, 6); nl = $urandom_range(1, 4);
            add_sym(c, l, nc, nl, (s != 3), (s != 5), 1);
            if (s == 1) bl[bl.size() - 3].tuser = 1'b1;
            c = nc; l = nl;
        end
        run_model(); send_all(); check_run("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
